// File: rtl/shifter_rr_arbiter_pkg.sv
// rtl/shifter_rr_arbiter_pkg.sv - shared widths and FSM encoding for the shifter arbiter
package shifter_rr_arbiter_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;
  localparam int ID_W    = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/right_barrel_shifter_8bits.sv
// rtl/right_barrel_shifter_8bits.sv - 8-bit rotate-right barrel shifter
module right_barrel_shifter_8bits (
  input  logic [7:0] D,
  input  logic [2:0] s,
  output logic [7:0] Q
);

  logic [7:0] stage1;
  logic [7:0] stage2;

  // Three log stages: rotate by 1, 2 and 4 positions.
  assign stage1 = s[0] ? {D[0], D[7:1]}           : D;
  assign stage2 = s[1] ? {stage1[1:0], stage1[7:2]} : stage1;
  assign Q      = s[2] ? {stage2[3:0], stage2[7:4]} : stage2;

endmodule

// File: rtl/shifter_rr_arbiter_rr_grant.sv
// rtl/shifter_rr_arbiter_rr_grant.sv - round-robin priority picker starting after last winner
module shifter_rr_arbiter_rr_grant
  import shifter_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Search last+1, last+2, ... modulo N_REQ; the first valid requester wins.
  always_comb begin
    int pos;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(last) + k) % N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!any && (i == pos) && valid[i]) begin
          grant[i] = 1'b1;
          idx      = ID_W'(i);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shifter_rr_arbiter.sv
// rtl/shifter_rr_arbiter.sv - round-robin sharing of one rotate-right shifter among requesters
module shifter_rr_arbiter
  import shifter_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 2  // legal range 2..4, bounded by the 2-bit response id
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [8*N_REQ-1:0]     req_data,
  input  logic [3*N_REQ-1:0]     req_shamt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            done_count
);

  logic [1:0]         state;
  logic [DATA_W-1:0]  op_data;
  logic [SHAMT_W-1:0] op_shamt;
  logic [ID_W-1:0]    op_id;
  logic [ID_W-1:0]    last;
  logic [15:0]        done_cnt;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [DATA_W-1:0]  sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic [DATA_W-1:0]  shift_q;

  shifter_rr_arbiter_rr_grant #(.N_REQ(N_REQ)) u_grant (
    .valid (req_valid),
    .last  (last),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  right_barrel_shifter_8bits u_shifter (
    .D (op_data),
    .s (op_shamt),
    .Q (shift_q)
  );

  // Offers are only made while idle and out of reset; the picker guarantees one-hot.
  assign req_ready  = (rst_n && (state == ST_IDLE)) ? grant : '0;
  assign done_count = done_cnt;

  // Route the granted requester's operand and shift amount to the capture registers.
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[DATA_W*i +: DATA_W];
        sel_shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
      end
    end
  end

  // Control FSM: capture a granted op, run it through the shifter, hold the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_data   <= '0;
      op_shamt  <= '0;
      op_id     <= '0;
      last      <= ID_W'(N_REQ - 1);
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            op_data  <= sel_data;
            op_shamt <= sel_shamt;
            op_id    <= grant_idx;
            last     <= grant_idx;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= shift_q;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// tb/tb_shifter_rr_arbiter.sv - directed vector bench for the shifter round-robin arbiter
module tb_shifter_rr_arbiter;

  localparam int N_REQ = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_data;
  logic [3*N_REQ-1:0] req_shamt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [7:0]         rsp_data;
  logic [1:0]         rsp_id;
  logic [15:0]        done_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_count;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [2:0] shamt;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  shifter_rr_arbiter #(.N_REQ(N_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shamt  (req_shamt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 16'd0;
  endtask

  // Starts on a falling edge with the block idle; returns on a falling edge with it idle again.
  task automatic run_op(input int id, input logic [7:0] d, input logic [2:0] sh, input logic [7:0] e);
    req_valid               = '0;
    req_valid[id]           = 1'b1;
    req_data[8*id +: 8]     = d;
    req_shamt[3*id +: 3]    = sh;
    rsp_ready               = 1'b1;
    #1;
    chk("grant_ready", 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("out_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("out_rsp_data", 32'(rsp_data), 32'(e));
    chk("out_rsp_id", 32'(rsp_id), 32'(id));
    chk("out_count", 32'(done_count), 32'(exp_count));
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_count", 32'(done_count), 32'(exp_count));
  endtask

  initial begin
    logic [1:0] ids[4];
    logic [7:0] dats[4];
    int         cyc[4];
    int         got;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    rsp_ready = 1'b1;
    exp_count = 16'd0;

    vecs[0]  = '{0, 8'h0F, 3'd1, 8'h87};
    vecs[1]  = '{1, 8'hCC, 3'd0, 8'hCC};
    vecs[2]  = '{1, 8'hCC, 3'd1, 8'h66};
    vecs[3]  = '{1, 8'hCC, 3'd2, 8'h33};
    vecs[4]  = '{1, 8'hCC, 3'd3, 8'h99};
    vecs[5]  = '{1, 8'hCC, 3'd4, 8'hCC};
    vecs[6]  = '{1, 8'hCC, 3'd5, 8'h66};
    vecs[7]  = '{1, 8'hCC, 3'd6, 8'h33};
    vecs[8]  = '{1, 8'hCC, 3'd7, 8'h99};
    vecs[9]  = '{1, 8'h0F, 3'd5, 8'h78};
    vecs[10] = '{0, 8'hA5, 3'd0, 8'hA5};
    vecs[11] = '{0, 8'h81, 3'd7, 8'h03};

    // Reset state, including no offers while rst_n is low even with requests pending.
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_count", 32'(done_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    #1;
    chk("idle_no_req", 32'(req_ready), 32'd0);
    @(negedge clk);

    // Table-driven single operations.
    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].id, vecs[v].data, vecs[v].shamt, vecs[v].exp);
    end

    // Both requesters held valid: grants alternate starting with requester 0.
    do_reset();
    req_valid          = 2'b11;
    req_data[7:0]      = 8'h01;
    req_shamt[2:0]     = 3'd1;
    req_data[15:8]     = 8'h02;
    req_shamt[5:3]     = 3'd1;
    rsp_ready          = 1'b1;
    #1;
    chk("fair_first_ready", 32'(req_ready), 32'b01);
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids[got]  = rsp_id;
        dats[got] = rsp_data;
        cyc[got]  = c;
        got++;
        if (got == 4) req_valid = '0;
      end
    end
    chk("fair_resp_count", 32'(got), 32'd4);
    if (got == 4) begin
      for (int g = 0; g < 4; g++) begin
        chk("fair_id", 32'(ids[g]), 32'(g % 2));
        chk("fair_data", 32'(dats[g]), (g % 2 == 0) ? 32'h80 : 32'h01);
      end
      for (int g = 1; g < 4; g++) begin
        chk("fair_spacing", 32'(cyc[g] - cyc[g-1]), 32'd3);
      end
    end
    @(negedge clk);
    chk("fair_count", 32'(done_count), 32'd4);

    // Backpressure: response held stable, no new offer while the consumer stalls.
    do_reset();
    req_valid      = 2'b01;
    req_data[7:0]  = 8'h3C;
    req_shamt[2:0] = 3'd2;
    rsp_ready      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid       = 2'b10;
    req_data[15:8]  = 8'h55;
    req_shamt[5:3]  = 3'd1;
    @(negedge clk);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'h0F);
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_count", 32'(done_count), 32'd1);
    chk("bp_next_ready", 32'(req_ready), 32'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("bp_second_data", 32'(rsp_data), 32'hAA);
    chk("bp_second_id", 32'(rsp_id), 32'd1);
    @(negedge clk);
    chk("bp_second_count", 32'(done_count), 32'd2);

    // Reset while the op is in EXEC: it vanishes and priority restarts at requester 0.
    req_valid      = 2'b01;
    req_data[7:0]  = 8'hF0;
    req_shamt[2:0] = 3'd3;
    rsp_ready      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst_count", 32'(done_count), 32'd0);
    @(negedge clk);
    req_valid       = 2'b11;
    req_data[7:0]   = 8'h12;
    req_shamt[2:0]  = 3'd4;
    req_data[15:8]  = 8'h34;
    req_shamt[5:3]  = 3'd4;
    #1;
    chk("midrst_held_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_first_ready", 32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    chk("midrst_exec_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("midrst_r0_data", 32'(rsp_data), 32'h21);
    chk("midrst_r0_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    chk("midrst_r0_count", 32'(done_count), 32'd1);
    chk("midrst_r1_ready", 32'(req_ready), 32'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("midrst_r1_data", 32'(rsp_data), 32'h43);
    chk("midrst_r1_id", 32'(rsp_id), 32'd1);
    @(negedge clk);
    chk("midrst_r1_count", 32'(done_count), 32'd2);

    // Counter wrap: preload the completion counter just below rollover.
    dut.done_cnt = 16'hFFFF;
    exp_count    = 16'hFFFF;
    #1;
    chk("wrap_preload", 32'(done_count), 32'hFFFF);
    run_op(0, 8'h80, 3'd7, 8'h01);
    chk("wrap_zero", 32'(done_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
